// File: rtl/disk_arb_pkg.sv
// Shared types and widths for the disk point arbiter.
// Purely declarative: no logic, no latency, no flow control.
package disk_arb_pkg;

    localparam int IDX_W    = 32;
    localparam int CFG_ID_W = 4;
    localparam int MAX_REQ  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RESEED,
        POP,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting one past last_grant.
// Zero latency; no backpressure, the caller decides when to accept the grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_grant,
    output logic [SEL_W-1:0]   grant,
    output logic               grant_vld
);

    int j;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        j         = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(last_grant) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_vld && req[SEL_W'(j)]) begin
                grant     = SEL_W'(j);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disk_arbiter.sv
// Shares one disk point generator among NUM_REQ streams, each with its own index.
// req->rsp_valid is 3+L cycles (L = generator latency); requesters hold req until their rsp_valid.
module disk_arbiter
    import disk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  rsp_valid,
    output logic [31:0]         rsp_x,
    output logic [31:0]         rsp_y,
    output logic                rsp_err,
    input  logic                cfg_we,
    input  logic [CFG_ID_W-1:0] cfg_id,
    input  logic [IDX_W-1:0]    cfg_seed,
    output logic                gen_reseed_enable,
    output logic [IDX_W-1:0]    gen_seed,
    output logic                gen_pop_enable,
    input  logic [31:0]         gen_disk_x,
    input  logic [31:0]         gen_disk_y,
    input  logic                gen_valid
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state;
    logic [SEL_W-1:0]     win;
    logic [SEL_W-1:0]     last_grant;
    logic [SEL_W-1:0]     pick;
    logic                 pick_vld;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx [NUM_REQ];
    logic [NUM_REQ-1:0]   win_onehot;
    logic [SEL_W-1:0]     cfg_sel;
    logic                 cfg_hit;

    assign win_onehot = NUM_REQ'(1) << win;
    assign cfg_sel    = cfg_id[SEL_W-1:0];
    assign cfg_hit    = cfg_we && (32'(cfg_id) < NUM_REQ);

    rr_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_vld  (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            win               <= '0;
            last_grant        <= SEL_W'(NUM_REQ - 1);
            cnt               <= '0;
            rsp_valid         <= '0;
            rsp_x             <= '0;
            rsp_y             <= '0;
            rsp_err           <= 1'b0;
            gen_reseed_enable <= 1'b0;
            gen_seed          <= '0;
            gen_pop_enable    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) idx[i] <= '0;
        end else begin
            gen_reseed_enable <= 1'b0;
            gen_seed          <= '0;
            gen_pop_enable    <= 1'b0;
            rsp_valid         <= '0;
            rsp_err           <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        win               <= pick;
                        last_grant        <= pick;
                        gen_reseed_enable <= 1'b1;
                        gen_seed          <= idx[pick];
                        state             <= RESEED;
                    end
                end
                RESEED: begin
                    gen_pop_enable <= 1'b1;
                    state          <= POP;
                end
                POP: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A point arriving on the final allowed cycle still counts as success.
                    if (gen_valid) begin
                        rsp_x     <= gen_disk_x;
                        rsp_y     <= gen_disk_y;
                        rsp_valid <= win_onehot;
                        state     <= RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= win_onehot;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (!rsp_err) idx[win] <= idx[win] + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Placed last so a coinciding config write overrides the RESP increment.
            if (cfg_hit) idx[cfg_sel] <= cfg_seed;
        end
    end

endmodule

// File: tb/tb_disk_arbiter.sv
// Self-checking bench: behavioural disk generator stub plus a stream-index reference model.
module tb_disk_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0]      rsp_valid;
    logic [31:0]     rsp_x, rsp_y;
    logic            rsp_err;
    logic            cfg_we;
    logic [3:0]      cfg_id;
    logic [31:0]     cfg_seed;
    logic            gen_reseed_enable, gen_pop_enable;
    logic [31:0]     gen_seed;
    logic [31:0]     gen_disk_x, gen_disk_y;
    logic            gen_valid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_idx [NREQ];
    int          m_last;
    logic [31:0] last_x;

    int          gen_lat;
    bit          gen_dead;
    bit          late_pulse;
    logic [31:0] g_cur;
    int          g_cnt;

    always #5 clk = ~clk;

    disk_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req),
        .rsp_valid         (rsp_valid),
        .rsp_x             (rsp_x),
        .rsp_y             (rsp_y),
        .rsp_err           (rsp_err),
        .cfg_we            (cfg_we),
        .cfg_id            (cfg_id),
        .cfg_seed          (cfg_seed),
        .gen_reseed_enable (gen_reseed_enable),
        .gen_seed          (gen_seed),
        .gen_pop_enable    (gen_pop_enable),
        .gen_disk_x        (gen_disk_x),
        .gen_disk_y        (gen_disk_y),
        .gen_valid         (gen_valid)
    );

    // Point n of the stream: any fixed, distinctive mapping will do for the stub.
    function automatic logic [31:0] fx(input logic [31:0] n);
        return (n * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] fy(input logic [31:0] n);
        return {n[15:0], n[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    // Generator stub: reseed k makes the next pop return point k+1, gen_valid after gen_lat cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_cnt <= 0;
        end else begin
            if (gen_reseed_enable) g_cur <= gen_seed;
            if (gen_pop_enable && !gen_dead) begin
                gen_disk_x <= fx(g_cur + 32'd1);
                gen_disk_y <= fy(g_cur + 32'd1);
                g_cur      <= g_cur + 32'd1;
                g_cnt      <= gen_lat;
            end else if (g_cnt > 0) begin
                g_cnt <= g_cnt - 1;
            end
        end
    end

    assign gen_valid = (g_cnt == 1) || late_pulse;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r);
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (m_last + i) % NREQ;
            if (r[2'(j)]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_idx[i] = 32'd0;
        m_last = NREQ - 1;
    endtask

    task automatic cfg_write(input logic [3:0] id, input logic [31:0] val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_id = id; cfg_seed = val;
        @(negedge clk);
        cfg_we = 1'b0;
        if (int'(id) < NREQ) m_idx[id[1:0]] = val;
    endtask

    // One request from idle through the response and the RESP->IDLE cycle.
    task automatic serve(input logic [3:0] r, input int drop_after, input bit cfg_at_resp,
                         input logic [31:0] cfg_val, input bit exp_err);
        int          w, n, lat;
        bit          got;
        logic [1:0]  ws;
        logic [3:0]  oh;
        logic [31:0] seed, nxt, seen;
        w    = pick(r);
        ws   = 2'(w);
        oh   = 4'b0001 << ws;
        seed = m_idx[ws];
        nxt  = seed + 32'd1;
        lat  = exp_err ? TMO : gen_lat;
        seen = 32'hDEAD_BEEF;
        got  = 1'b0;
        n    = 0;
        @(negedge clk);
        req = r;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (drop_after != 0 && n == drop_after) req = '0;
            if (gen_reseed_enable) seen = gen_seed;
            if (rsp_valid != '0) got = 1'b1;
        end
        check("rsp_seen", 64'(got), 64'd1);
        if (got) begin
            check("rsp_latency", 64'(n), 64'(3 + lat));
            check("rsp_valid_onehot", 64'(rsp_valid), 64'(oh));
            check("rsp_err", 64'(rsp_err), 64'(exp_err));
            check("rsp_x", 64'(rsp_x), exp_err ? 64'd0 : 64'(fx(nxt)));
            check("rsp_y", 64'(rsp_y), exp_err ? 64'd0 : 64'(fy(nxt)));
            check("gen_seed", 64'(seen), 64'(seed));
            last_x = exp_err ? 32'd0 : fx(nxt);
            if (!exp_err) m_idx[ws] = nxt;
            m_last = w;
        end
        req = '0;
        if (cfg_at_resp) begin
            cfg_we = 1'b1; cfg_id = 4'(w); cfg_seed = cfg_val;
            m_idx[ws] = cfg_val;
        end
        @(negedge clk);
        cfg_we = 1'b0;
        check("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int          n, k, last_n, w;
        bit          bad;
        logic [1:0]  ws;
        logic [3:0]  r;

        rst_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_id = '0; cfg_seed = '0;
        gen_lat = 1; gen_dead = 1'b0; late_pulse = 1'b0;
        g_cur = '0; gen_disk_x = '0; gen_disk_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_flags", 64'({rsp_err, gen_reseed_enable, gen_pop_enable}), 64'd0);
        check("rst_rsp_x", 64'(rsp_x), 64'd0);
        check("rst_rsp_y", 64'(rsp_y), 64'd0);
        check("rst_gen_seed", 64'(gen_seed), 64'd0);
        rst_n = 1'b1;

        // All requesters held: rotation order and back-to-back spacing of 4+L.
        gen_lat = 2;
        @(negedge clk);
        req = 4'hF; n = 0; k = 0; last_n = 0;
        while (k < 5 && n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid != '0) begin
                w  = pick(4'hF);
                ws = 2'(w);
                check("held_grant", 64'(rsp_valid), 64'(4'b0001 << ws));
                check("held_x", 64'(rsp_x), 64'(fx(m_idx[ws] + 32'd1)));
                if (k == 0) check("held_first_lat", 64'(n), 64'(3 + gen_lat));
                else        check("held_spacing", 64'(n - last_n), 64'(4 + gen_lat));
                last_n = n;
                m_idx[ws] = m_idx[ws] + 32'd1;
                m_last = w;
                k++;
                if (k == 5) req = '0;
            end
        end
        check("held_count", 64'(k), 64'd5);
        @(negedge clk);

        // Single stream repeated, L=1.
        gen_lat = 1;
        for (int i = 0; i < 5; i++) serve(4'b0001, 0, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("rsp_x_hold", 64'(rsp_x), 64'(last_x));

        // Config writes, wrap-around, out-of-range id, write coinciding with RESP.
        cfg_write(4'd2, 32'd5);
        serve(4'b0100, 0, 1'b0, 32'd0, 1'b0);
        serve(4'b0100, 0, 1'b0, 32'd0, 1'b0);
        cfg_write(4'd1, 32'hFFFF_FFFF);
        serve(4'b0010, 0, 1'b0, 32'd0, 1'b0);
        serve(4'b0010, 0, 1'b0, 32'd0, 1'b0);
        cfg_write(4'd4, 32'h0000_1234);
        serve(4'b0001, 0, 1'b0, 32'd0, 1'b0);
        serve(4'b0001, 0, 1'b1, 32'h0000_0100, 1'b0);
        serve(4'b0001, 0, 1'b0, 32'd0, 1'b0);

        // Request dropped mid-service still completes.
        serve(4'b1000, 2, 1'b0, 32'd0, 1'b0);
        serve(4'b1000, 0, 1'b0, 32'd0, 1'b0);

        // Dead generator: timeout response, then a late gen_valid must be ignored.
        gen_dead = 1'b1;
        serve(4'b0001, 0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        late_pulse = 1'b1;
        @(negedge clk);
        late_pulse = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid != '0) bad = 1'b1;
        end
        check("late_valid_ignored", 64'(bad), 64'd0);
        check("err_x_held", 64'(rsp_x), 64'd0);
        gen_dead = 1'b0;
        serve(4'b0001, 0, 1'b0, 32'd0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 20; i++) begin
            gen_lat = int'($urandom_range(1, 3));
            r = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0)
                cfg_write(4'($urandom_range(0, 5)), $urandom);
            serve(r, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, 32'd0, 1'b0);
        end

        // Reset during WAIT: outputs clear at once, no response, fresh start afterwards.
        gen_lat = 3;
        @(negedge clk);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        check("mid_in_wait_no_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_flags", 64'({rsp_err, gen_reseed_enable, gen_pop_enable}), 64'd0);
        check("mid_rst_rsp_x", 64'(rsp_x), 64'd0);
        check("mid_rst_rsp_y", 64'(rsp_y), 64'd0);
        req = '0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != '0) bad = 1'b1;
        end
        check("mid_rst_no_rsp", 64'(bad), 64'd0);
        rst_n = 1'b1;
        model_reset();
        gen_lat = 1;
        serve(4'b0001, 0, 1'b0, 32'd0, 1'b0);
        serve(4'b0011, 0, 1'b0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
